ysyx_041461_mem_lsu: RTL and testbench

//  MEM stage of the 5-stage core: takes one load/store per transaction from EXE and runs it on a 64-bit data bus.

---
 rtl/ysyx_041461_lsu_pkg.sv | 73 +++++++
 rtl/ysyx_041461_lsu_align.sv | 57 +++++
 rtl/ysyx_041461_mem_lsu.sv | 166 ++++++++++++++++
 tb/tb_ysyx_041461_mem_lsu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_041461_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_041461_lsu_pkg
//  Description : Shared definitions for the MEM-stage load/store unit:
//                LSU op encodings, trap codes shared with WB, FSM state
//                enum and small op-decode helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_041461_lsu_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int TRAP_W_DEF = 4;

    // LSU op encodings
    localparam logic [3:0] LSU_NOP = 4'd0;
    localparam logic [3:0] LSU_LB  = 4'd1;
    localparam logic [3:0] LSU_LH  = 4'd2;
    localparam logic [3:0] LSU_LW  = 4'd3;
    localparam logic [3:0] LSU_LD  = 4'd4;
    localparam logic [3:0] LSU_LBU = 4'd5;
    localparam logic [3:0] LSU_LHU = 4'd6;
    localparam logic [3:0] LSU_LWU = 4'd7;
    localparam logic [3:0] LSU_SB  = 4'd8;
    localparam logic [3:0] LSU_SH  = 4'd9;
    localparam logic [3:0] LSU_SW  = 4'd10;
    localparam logic [3:0] LSU_SD  = 4'd11;

    // Trap codes (RISC-V exception cause numbers for the misaligned cases)
    localparam logic [3:0] TRAP_NOP           = 4'd0;
    localparam logic [3:0] MEM_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] MEM_STORE_MISALIGN = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } lsu_state_e;

    function automatic logic lsu_is_mem(input logic [3:0] op);
        return (op >= LSU_LB) && (op <= LSU_SD);
    endfunction

    function automatic logic lsu_is_store(input logic [3:0] op);
        return (op >= LSU_SB) && (op <= LSU_SD);
    endfunction

    // log2 of the access size in bytes; non-memory ops report byte size
    function automatic logic [1:0] lsu_size(input logic [3:0] op);
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: return 2'd1;
            LSU_LW, LSU_LWU, LSU_SW: return 2'd2;
            LSU_LD, LSU_SD:          return 2'd3;
            default:                 return 2'd0;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] lsu_align_mask(input logic [3:0] op);
        case (lsu_size(op))
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            2'd3:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [3:0] op, input logic [2:0] lo);
        return lsu_is_mem(op) && ((lo & lsu_align_mask(op)) != 3'b000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_041461_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_041461_lsu_align
//  Description : Combinational byte-lane steering for the LSU.
//                Loads : lane = rdata >> 8*addr_lo, then sign/zero extend.
//                Stores: wdata << 8*addr_lo, size mask << addr_lo.
//  Ports       : i_op, i_addr_lo, i_wdata, i_rdata -> o_load_data,
//                o_st_wdata, o_st_wmask
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_041461_lsu_align
    import ysyx_041461_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      i_op,
    input  logic [2:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_load_data,
    output logic [XLEN-1:0] o_st_wdata,
    output logic [7:0]      o_st_wmask
);

    logic [5:0]      w_shift;
    logic [XLEN-1:0] w_lane;
    logic [7:0]      w_size_mask;

    always_comb begin
        w_shift = {i_addr_lo, 3'b000};
        w_lane  = i_rdata >> w_shift;

        case (i_op)
            LSU_LB:  o_load_data = {{(XLEN-8){w_lane[7]}},   w_lane[7:0]};
            LSU_LBU: o_load_data = {{(XLEN-8){1'b0}},        w_lane[7:0]};
            LSU_LH:  o_load_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            LSU_LHU: o_load_data = {{(XLEN-16){1'b0}},       w_lane[15:0]};
            LSU_LW:  o_load_data = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
            LSU_LWU: o_load_data = {{(XLEN-32){1'b0}},       w_lane[31:0]};
            LSU_LD:  o_load_data = w_lane;
            default: o_load_data = '0;
        endcase

        case (lsu_size(i_op))
            2'd1:    w_size_mask = 8'h03;
            2'd2:    w_size_mask = 8'h0F;
            2'd3:    w_size_mask = 8'hFF;
            default: w_size_mask = 8'h01;
        endcase

        o_st_wdata = i_wdata << w_shift;
        // Byte enables are driven for every memory op; NOP gives an empty mask
        o_st_wmask = lsu_is_mem(i_op) ? (w_size_mask << i_addr_lo) : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_041461_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_041461_mem_lsu
//  Description : MEM stage of the 5-stage core. Accepts one load/store from
//                EXE, runs it on a 64-bit data bus, aligns/extends load data
//                and hands result + trap code to WB (valid/ready).
//                Config macro YSYX_041461_LSU_MISALIGN_TRAP_EN: when defined,
//                misaligned accesses trap without bus traffic; otherwise the
//                address is aligned down to the access size.
//  Ports       : clk/rst; in_* (EXE side), out_* (WB side),
//                mem_req_* / mem_resp_* (data bus)
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_041461_mem_lsu
    import ysyx_041461_lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int TRAP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [TRAP_W-1:0] in_trap,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_rdata,
    output logic [TRAP_W-1:0] out_trap,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata
);

    lsu_state_e        state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [3:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [TRAP_W-1:0] trap_q, trap_d;

    logic              w_mis_trap;
    logic [XLEN-1:0]   w_addr_eff;
    logic [TRAP_W-1:0] w_in_trap;
    logic              w_skip_bus;
    logic [XLEN-1:0]   w_load_data;

    ysyx_041461_lsu_align #(.XLEN(XLEN)) u_align (
        .i_op        (op_q),
        .i_addr_lo   (addr_q[2:0]),
        .i_wdata     (wdata_q),
        .i_rdata     (mem_resp_rdata),
        .o_load_data (w_load_data),
        .o_st_wdata  (mem_req_wdata),
        .o_st_wmask  (mem_req_wmask)
    );

    // Misalignment policy: trap, or silently align down to the access size
    always_comb begin
`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
        w_mis_trap = lsu_misaligned(in_op, in_addr[2:0]);
        w_addr_eff = in_addr;
`else
        w_mis_trap = 1'b0;
        w_addr_eff = in_addr & ~{{(XLEN-3){1'b0}}, lsu_align_mask(in_op)};
`endif
        // Upstream trap wins over a locally detected misalignment
        if (in_trap != TRAP_W'(TRAP_NOP))
            w_in_trap = in_trap;
        else if (w_mis_trap)
            w_in_trap = lsu_is_store(in_op) ? TRAP_W'(MEM_STORE_MISALIGN)
                                            : TRAP_W'(MEM_LOAD_MISALIGN);
        else
            w_in_trap = TRAP_W'(TRAP_NOP);

        w_skip_bus = (in_trap != TRAP_W'(TRAP_NOP)) || !lsu_is_mem(in_op) || w_mis_trap;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        op_d    = op_q;
        rd_d    = rd_q;
        trap_d  = trap_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pc_d    = in_pc;
                    addr_d  = w_addr_eff;
                    wdata_d = in_wdata;
                    op_d    = in_op;
                    rd_d    = in_rd;
                    trap_d  = w_in_trap;
                    rdata_d = '0;
                    state_d = w_skip_bus ? ST_HOLD : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Stores complete on the same ack but return no data
                if (mem_resp_valid) begin
                    rdata_d = lsu_is_store(op_q) ? '0 : w_load_data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_q    <= LSU_NOP;
            rd_q    <= '0;
            trap_q  <= TRAP_W'(TRAP_NOP);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            trap_q  <= trap_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_HOLD);
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_wen   = lsu_is_store(op_q);
    assign mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
    assign out_pc        = pc_q;
    assign out_rd        = rd_q;
    assign out_rdata     = rdata_q;
    assign out_trap      = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_041461_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_041461_mem_lsu
//  Description : Self-checking bench for ysyx_041461_mem_lsu. Expected WB
//                results are queued when a transaction is driven and popped
//                when the DUT presents out_valid. Honours the
//                YSYX_041461_LSU_MISALIGN_TRAP_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_041461_mem_lsu;
    import ysyx_041461_lsu_pkg::*;

    localparam logic [3:0] ID_ECALL = 4'd11;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [63:0] in_pc, in_addr, in_wdata;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [3:0]  in_trap;
    logic        out_valid, out_ready;
    logic [63:0] out_pc, out_rdata;
    logic [4:0]  out_rd;
    logic [3:0]  out_trap;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic [3:0]  trap;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    ysyx_041461_mem_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_op          (in_op),
        .in_rd          (in_rd),
        .in_trap        (in_trap),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_rd         (out_rd),
        .out_rdata      (out_rdata),
        .out_trap       (out_trap),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with exact-cycle expectations.
    task automatic run_txn(
        input string       name,
        input logic [63:0] pc, input logic [63:0] addr, input logic [63:0] wdata,
        input logic [3:0]  op, input logic [4:0] rd, input logic [3:0] trap,
        input logic [63:0] resp, input bit bus,
        input logic [63:0] exp_addr, input logic [63:0] exp_wdata, input logic [7:0] exp_wmask,
        input logic [63:0] exp_rdata, input logic [3:0] exp_trap,
        input int req_stall, input int out_stall);
        exp_t e;
        bit   is_st;
        is_st = (op >= LSU_SB) && (op <= LSU_SD);
        sb_q.push_back('{pc: pc, rd: rd, rdata: exp_rdata, trap: exp_trap});

        check_eq({name, ".in_ready_idle"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_pc = pc; in_addr = addr; in_wdata = wdata;
        in_op = op; in_rd = rd; in_trap = trap;
        tick();
        in_valid = 1'b0; in_op = LSU_NOP; in_addr = '1; in_wdata = '1;

        if (bus) begin
            for (int i = 0; i <= req_stall; i++) begin
                check_eq({name, ".req_valid"}, {63'd0, mem_req_valid}, 64'd1);
                check_eq({name, ".req_addr"}, mem_req_addr, exp_addr);
                check_eq({name, ".req_wen"}, {63'd0, mem_req_wen}, {63'd0, is_st});
                if (is_st) begin
                    check_eq({name, ".req_wdata"}, mem_req_wdata, exp_wdata);
                    check_eq({name, ".req_wmask"}, {56'd0, mem_req_wmask}, {56'd0, exp_wmask});
                end
                if (i == req_stall) mem_req_ready = 1'b1;
                tick();
            end
            mem_req_ready = 1'b0;
            check_eq({name, ".req_drop"}, {63'd0, mem_req_valid}, 64'd0);
            check_eq({name, ".no_early_out"}, {63'd0, out_valid}, 64'd0);
            mem_resp_valid = 1'b1; mem_resp_rdata = resp;
            tick();
            mem_resp_valid = 1'b0; mem_resp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        end else begin
            check_eq({name, ".no_req"}, {63'd0, mem_req_valid}, 64'd0);
        end

        for (int i = 0; i <= out_stall; i++) begin
            check_eq({name, ".out_valid"}, {63'd0, out_valid}, 64'd1);
            check_eq({name, ".hold_no_accept"}, {63'd0, in_ready}, 64'd0);
            if (sb_q.size() == 0) begin
                check_eq({name, ".sb_empty"}, 64'd1, 64'd0);
            end else begin
                e = sb_q[0];
                check_eq({name, ".out_pc"}, out_pc, e.pc);
                check_eq({name, ".out_rd"}, {59'd0, out_rd}, {59'd0, e.rd});
                check_eq({name, ".out_rdata"}, out_rdata, e.rdata);
                check_eq({name, ".out_trap"}, {60'd0, out_trap}, {60'd0, e.trap});
            end
            if (i == out_stall) begin
                out_ready = 1'b1;
                if (sb_q.size() != 0) void'(sb_q.pop_front());
            end
            tick();
        end
        out_ready = 1'b0;
        check_eq({name, ".out_drop"}, {63'd0, out_valid}, 64'd0);
        check_eq({name, ".back_idle"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [3:0]  mis_ld_trap, mis_sd_trap;
        bit          mis_bus;
        logic [63:0] mis_rd;

        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_addr = '0; in_wdata = '0;
        in_op = LSU_NOP; in_rd = '0; in_trap = TRAP_NOP; out_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;

        check_eq("rst.out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst.req_valid", {63'd0, mem_req_valid}, 64'd0);
        check_eq("rst.out_rdata", out_rdata, 64'd0);
        check_eq("rst.out_trap", {60'd0, out_trap}, 64'd0);
        check_eq("rst.out_pc", out_pc, 64'd0);
        check_eq("rst.out_rd", {59'd0, out_rd}, 64'd0);
        check_eq("rst.wmask", {56'd0, mem_req_wmask}, 64'd0);
        check_eq("rst.in_ready", {63'd0, in_ready}, 64'd1);

        run_txn("ld", 64'h8000_1000, 64'h8000_0010, 64'd0, LSU_LD, 5'd1, TRAP_NOP,
                64'h1122_3344_5566_7788, 1'b1, 64'h8000_0010, 64'd0, 8'h00,
                64'h1122_3344_5566_7788, TRAP_NOP, 0, 0);
        run_txn("lb", 64'h8000_1004, 64'h8000_0013, 64'd0, LSU_LB, 5'd2, TRAP_NOP,
                64'h0000_0000_8000_0000, 1'b1, 64'h8000_0010, 64'd0, 8'h00,
                64'hFFFF_FFFF_FFFF_FF80, TRAP_NOP, 0, 0);
        run_txn("lbu", 64'h8000_1008, 64'h8000_0013, 64'd0, LSU_LBU, 5'd3, TRAP_NOP,
                64'h0000_0000_8000_0000, 1'b1, 64'h8000_0010, 64'd0, 8'h00,
                64'h0000_0000_0000_0080, TRAP_NOP, 0, 0);
        run_txn("sh", 64'h8000_100C, 64'h8000_0006, 64'h0000_0000_0000_ABCD, LSU_SH, 5'd0, TRAP_NOP,
                64'h5555_5555_5555_5555, 1'b1, 64'h8000_0000, 64'hABCD_0000_0000_0000, 8'hC0,
                64'd0, TRAP_NOP, 0, 0);
        run_txn("lh", 64'h8000_1010, 64'h8000_0022, 64'd0, LSU_LH, 5'd4, TRAP_NOP,
                64'h0000_0000_8001_0000, 1'b1, 64'h8000_0020, 64'd0, 8'h00,
                64'hFFFF_FFFF_FFFF_8001, TRAP_NOP, 0, 0);
        run_txn("lwu", 64'h8000_1014, 64'h8000_0024, 64'd0, LSU_LWU, 5'd5, TRAP_NOP,
                64'hDEAD_BEEF_0000_0000, 1'b1, 64'h8000_0020, 64'd0, 8'h00,
                64'h0000_0000_DEAD_BEEF, TRAP_NOP, 0, 0);
        run_txn("lw", 64'h8000_1018, 64'h8000_0024, 64'd0, LSU_LW, 5'd6, TRAP_NOP,
                64'hDEAD_BEEF_0000_0000, 1'b1, 64'h8000_0020, 64'd0, 8'h00,
                64'hFFFF_FFFF_DEAD_BEEF, TRAP_NOP, 0, 0);
        run_txn("sw", 64'h8000_101C, 64'h8000_0004, 64'h0000_0000_1234_5678, LSU_SW, 5'd0, TRAP_NOP,
                64'd0, 1'b1, 64'h8000_0000, 64'h1234_5678_0000_0000, 8'hF0,
                64'd0, TRAP_NOP, 0, 0);
        run_txn("sb", 64'h8000_1020, 64'h8000_0001, 64'h0000_0000_FFFF_FFA5, LSU_SB, 5'd0, TRAP_NOP,
                64'd0, 1'b1, 64'h8000_0000, 64'h0000_00FF_FFFF_A500, 8'h02,
                64'd0, TRAP_NOP, 0, 0);

`ifdef YSYX_041461_LSU_MISALIGN_TRAP_EN
        mis_ld_trap = MEM_LOAD_MISALIGN;
        mis_sd_trap = MEM_STORE_MISALIGN;
        mis_bus     = 1'b0;
        mis_rd      = 64'd0;
`else
        mis_ld_trap = TRAP_NOP;
        mis_sd_trap = TRAP_NOP;
        mis_bus     = 1'b1;
        mis_rd      = 64'h0000_0000_7FFF_1234;
`endif
        run_txn("lw_mis", 64'h8000_1024, 64'h8000_0002, 64'd0, LSU_LW, 5'd7, TRAP_NOP,
                64'hAAAA_AAAA_7FFF_1234, mis_bus, 64'h8000_0000, 64'd0, 8'h00,
                mis_rd, mis_ld_trap, 0, 0);
        run_txn("sd_mis", 64'h8000_1028, 64'h8000_0003, 64'h0102_0304_0506_0708, LSU_SD, 5'd0, TRAP_NOP,
                64'd0, mis_bus, 64'h8000_0000, 64'h0102_0304_0506_0708, 8'hFF,
                64'd0, mis_sd_trap, 0, 0);

        run_txn("ecall", 64'h8000_102C, 64'h8000_0003, 64'h1111, LSU_SD, 5'd8, ID_ECALL,
                64'd0, 1'b0, 64'd0, 64'd0, 8'h00, 64'd0, ID_ECALL, 0, 0);
        run_txn("nop", 64'h8000_1030, 64'h8000_0040, 64'd0, LSU_NOP, 5'd9, TRAP_NOP,
                64'd0, 1'b0, 64'd0, 64'd0, 8'h00, 64'd0, TRAP_NOP, 0, 0);
        run_txn("stall", 64'h8000_1034, 64'h8000_0048, 64'd0, LSU_LD, 5'd10, TRAP_NOP,
                64'hCAFE_F00D_1234_5678, 1'b1, 64'h8000_0048, 64'd0, 8'h00,
                64'hCAFE_F00D_1234_5678, TRAP_NOP, 5, 3);

        // Reset taken while waiting for a response, then a stale response
        in_valid = 1'b1; in_pc = 64'h8000_2000; in_addr = 64'h8000_0050;
        in_op = LSU_LD; in_rd = 5'd11; in_trap = TRAP_NOP;
        tick();
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstwait.in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("rstwait.req_valid", {63'd0, mem_req_valid}, 64'd0);
        check_eq("rstwait.out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rstwait.out_pc", out_pc, 64'd0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        mem_resp_valid = 1'b0;
        check_eq("stale.out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("stale.in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("stale.out_rdata", out_rdata, 64'd0);

        run_txn("after_rst", 64'h8000_2004, 64'h8000_0058, 64'd0, LSU_LHU, 5'd12, TRAP_NOP,
                64'h0000_0000_0000_F00F, 1'b1, 64'h8000_0058, 64'd0, 8'h00,
                64'h0000_0000_0000_F00F, TRAP_NOP, 1, 1);

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
